// File: rtl/rf_wb_arbiter_pkg.sv
// Shared constants for the register-file writeback arbiter.
// Defaults for the datapath widths, the hardwired-zero register and the requester indices.
package rf_wb_arbiter_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  localparam int ZERO_REG = 0;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

endpackage

// File: rtl/rf_wb_arbiter_rr_arb2.sv
// Combinational 2-way round-robin arbiter.
// The parent module holds the priority pointer.
module rr_arb2
  import rf_wb_arbiter_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       prio,
  output logic [1:0] grant
);

  // A lone requester always wins; when both request, prio breaks the tie.
  always_comb begin
    grant        = 2'b00;
    grant[REQ_A] = valid[REQ_A] & (~valid[REQ_B] | (prio == REQ_A));
    grant[REQ_B] = valid[REQ_B] & (~valid[REQ_A] | (prio == REQ_B));
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the register file write port between the ALU (A) and load (B) writeback paths.
// Registers the winning write and exposes a hazard compare against the staged write.
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter bit DROP_X0 = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              rf_wren,
  output logic [ADDR_W-1:0] rf_wr,
  output logic [DATA_W-1:0] rf_wd,
  input  logic [ADDR_W-1:0] chk_addr,
  output logic              chk_hit,
  output logic              last_grant
);

  logic              prio;
  logic [1:0]        grant;
  logic              any_grant;
  logic              win_b;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;

  rr_arb2 u_arb (
    .valid ({b_valid, a_valid}),
    .prio  (prio),
    .grant (grant)
  );

  // Ready is suppressed while reset is held so no handshake can complete.
  assign a_ready   = rst_n & grant[REQ_A];
  assign b_ready   = rst_n & grant[REQ_B];
  assign any_grant = |grant;
  assign win_b     = grant[REQ_B];
  assign win_addr  = win_b ? b_addr : a_addr;
  assign win_data  = win_b ? b_data : a_data;

  // The loser of each grant gets the next tie; idle cycles leave the pointer alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio       <= REQ_A;
      last_grant <= REQ_B;
      rf_wren    <= 1'b0;
      rf_wr      <= '0;
      rf_wd      <= '0;
    end else if (any_grant) begin
      prio       <= ~win_b;
      last_grant <= win_b;
      rf_wr      <= win_addr;
      rf_wd      <= win_data;
      rf_wren    <= !(DROP_X0 && (win_addr == ADDR_W'(ZERO_REG)));
    end else begin
      rf_wren    <= 1'b0;
    end
  end

  assign chk_hit = rf_wren && (rf_wr == chk_addr);

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed plan steps followed by a randomized phase.
// Expected values come from a transaction-level model of the arbitration rules.
module tb_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_valid, b_valid;
  logic        a_ready, b_ready;
  logic [4:0]  a_addr, b_addr;
  logic [31:0] a_data, b_data;
  logic        rf_wren;
  logic [4:0]  rf_wr;
  logic [31:0] rf_wd;
  logic [4:0]  chk_addr;
  logic        chk_hit;
  logic        last_grant;

  int checks   = 0;
  int failures = 0;

  // Model state: whose turn it is on a tie, last winner and the staged write.
  int          mTurn;
  int          mLast;
  logic        mWren;
  logic [4:0]  mWr;
  logic [31:0] mWd;
  int          lastWinner;

  rf_wb_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .a_valid    (a_valid),
    .a_ready    (a_ready),
    .a_addr     (a_addr),
    .a_data     (a_data),
    .b_valid    (b_valid),
    .b_ready    (b_ready),
    .b_addr     (b_addr),
    .b_data     (b_data),
    .rf_wren    (rf_wren),
    .rf_wr      (rf_wr),
    .rf_wd      (rf_wd),
    .chk_addr   (chk_addr),
    .chk_hit    (chk_hit),
    .last_grant (last_grant)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      checks++;
      assert (!$isunknown({a_valid, b_valid})) else begin
        failures++;
        $error("[TB] FAIL x_valid observed=%b%b expected=known", a_valid, b_valid);
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int pickWinner(input logic av, input logic bv);
    if (av && bv) return mTurn;
    if (av) return 0;
    if (bv) return 1;
    return -1;
  endfunction

  task automatic modelReset();
    mTurn = 0;
    mLast = 1;
    mWren = 1'b0;
    mWr   = '0;
    mWd   = '0;
  endtask

  task automatic checkHit(input logic [4:0] ca);
    chk_addr = ca;
    #1;
    checkOutput("chk_hit", {31'b0, chk_hit}, {31'b0, (mWren && (mWr == ca))});
  endtask

  // One clock of traffic: check readies before the edge, staged write after it.
  task automatic applyStimulus(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                               input logic bv, input logic [4:0] ba, input logic [31:0] bd,
                               input logic [4:0] ca);
    int w;
    a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
    #1;
    w = pickWinner(av, bv);
    lastWinner = w;
    checkOutput("a_ready", {31'b0, a_ready}, {31'b0, (w == 0)});
    checkOutput("b_ready", {31'b0, b_ready}, {31'b0, (w == 1)});
    @(posedge clk);
    if (w >= 0) begin
      mTurn = 1 - w;
      mLast = w;
      mWr   = (w == 1) ? ba : aa;
      mWd   = (w == 1) ? bd : ad;
      mWren = (mWr != 5'd0);
    end else begin
      mWren = 1'b0;
    end
    #1;
    checkOutput("rf_wren", {31'b0, rf_wren}, {31'b0, mWren});
    checkOutput("rf_wr", {27'b0, rf_wr}, {27'b0, mWr});
    checkOutput("rf_wd", rf_wd, mWd);
    checkOutput("last_grant", {31'b0, last_grant}, mLast[31:0]);
    checkHit(ca);
  endtask

  initial begin
    logic        av, bv, holdA, holdB;
    logic [4:0]  aa, ba, ca;
    logic [31:0] ad, bd;

    rst_n = 1'b0;
    a_valid = 1'b1; b_valid = 1'b1;
    a_addr = 5'd1; b_addr = 5'd2; a_data = 32'h1; b_data = 32'h2;
    chk_addr = 5'd0;
    modelReset();
    lastWinner = -1;
    $display("[TB] reset with both requesters valid");
    #3;
    checkOutput("rst_a_ready", {31'b0, a_ready}, 32'd0);
    checkOutput("rst_b_ready", {31'b0, b_ready}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_rf_wren", {31'b0, rf_wren}, 32'd0);
    checkOutput("rst_rf_wr", {27'b0, rf_wr}, 32'd0);
    checkOutput("rst_rf_wd", rf_wd, 32'd0);
    checkOutput("rst_last_grant", {31'b0, last_grant}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    $display("[TB] contention A=3/0x11 B=7/0x22 for 4 cycles");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 5'd3, 32'h11, 1'b1, 5'd7, 32'h22, 5'd3);
      checkOutput("contend_winner", lastWinner[31:0], (i % 2 == 0) ? 32'd0 : 32'd1);
    end

    $display("[TB] single requester A");
    applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 5'd5);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd5);

    $display("[TB] write to x0 from B");
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0);
    applyStimulus(1'b1, 5'd4, 32'h44, 1'b1, 5'd6, 32'h66, 5'd4);
    checkOutput("x0_ptr_to_a", lastWinner[31:0], 32'd0);

    $display("[TB] hazard compare");
    applyStimulus(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'h0, 5'd9);
    checkHit(5'd10);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd9);

    $display("[TB] async reset mid-stream");
    applyStimulus(1'b1, 5'd12, 32'hCAFE, 1'b0, 5'd0, 32'h0, 5'd12);
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput("async_rf_wren", {31'b0, rf_wren}, 32'd0);
    checkOutput("async_a_ready", {31'b0, a_ready}, 32'd0);
    checkOutput("async_rf_wr", {27'b0, rf_wr}, 32'd0);
    a_valid = 1'b0; b_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd12);
    applyStimulus(1'b1, 5'd1, 32'h101, 1'b1, 5'd2, 32'h202, 5'd1);

    $display("[TB] randomized traffic");
    holdA = 1'b0; holdB = 1'b0;
    aa = '0; ba = '0; ad = '0; bd = '0;
    for (int i = 0; i < 300; i++) begin
      if (holdA) av = 1'b1;
      else begin
        av = ($urandom_range(0, 3) != 0);
        aa = 5'($urandom_range(0, 31));
        ad = $urandom;
      end
      if (holdB) bv = 1'b1;
      else begin
        bv = ($urandom_range(0, 3) != 0);
        ba = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        bd = $urandom;
      end
      ca = ($urandom_range(0, 1) == 0) ? mWr : 5'($urandom_range(0, 31));
      applyStimulus(av, aa, ad, bv, ba, bd, ca);
      holdA = av && (lastWinner != 0);
      holdB = bv && (lastWinner != 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the register file's single write port between two writeback requesters: A (ALU result) and B (load/memory result).
- Each requester presents a valid/ready handshake.
- The block arbitrates round-robin, registers the winning write, and drives the register file's write-enable, write-address and write-data inputs.
- It also reports in-flight writes so the read-side control can detect hazards against the register file's one-cycle synchronous read.

Parameters:
- DATA_W, 32, width of write data.
- ADDR_W, 5, width of register address (32 registers).
- DROP_X0, 1, when 1 a write to address 0 is accepted but never asserts rf_wren.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- a_valid  in  1  requester A has a write pending.
- a_ready  out  1  A's write is accepted this cycle (transfer when a_valid and a_ready).
- a_addr  in  ADDR_W  A destination register.
- a_data  in  DATA_W  A write data.
- b_valid  in  1  requester B has a write pending.
- b_ready  out  1  B's write is accepted this cycle.
- b_addr  in  ADDR_W  B destination register.
- b_data  in  DATA_W  B write data.
- rf_wren  out  1  register file write enable.
- rf_wr  out  ADDR_W  register file write address.
- rf_wd  out  DATA_W  register file write data.
- chk_addr  in  ADDR_W  read address to be checked for hazard.
- chk_hit  out  1  a write to chk_addr is in the output stage (combinational compare, only when rf_wren=1).
- last_grant  out  1  0 = A won the most recent arbitration, 1 = B.

Behaviour:
- Reset (rst_n low, asynchronous) forces:
  - rf_wren=0, rf_wr=0, rf_wd=0.
  - last_grant=1, so A has priority first after reset.
  - prio pointer = A.
- a_ready/b_ready are combinational from valids and prio; they are 0 during reset.
- Arbitration, evaluated every cycle (no backpressure from the register file; one grant per cycle max):
  - Only A valid: a_ready=1, b_ready=0.
  - Only B valid: b_ready=1, a_ready=0.
  - Both valid: the requester selected by prio gets ready=1; the other gets 0 and must hold valid/addr/data stable.
  - Neither valid: both ready=0. Next edge: rf_wren=0, rf_wr/rf_wd hold their previous values.
- Pointer update on a grant edge: prio and last_grant change only on cycles with a grant.
  - prio <= the requester that lost (or did not win).
  - last_grant <= the winner.
- Output stage on a grant edge:
  - rf_wr <= winner addr.
  - rf_wd <= winner data.
  - rf_wren <= 1, except 0 when DROP_X0=1 and addr==0.
- Latency: accepted at edge N, rf_wren visible after edge N, register file written at edge N+1. Net: 2 edges from handshake to the register contents updating.
- Throughput: 1 write per cycle sustained. Under continuous contention, A and B alternate strictly; neither waits more than 1 cycle.
- Hazard check: chk_hit = rf_wren && (rf_wr == chk_addr). Address 0 never hits when DROP_X0=1.
- Reset mid-operation: any staged write is discarded (rf_wren forced 0 immediately); a pending grant is lost. Requesters must re-present after rst_n rises.
- X/unknown valid must not occur post-reset; the bench asserts this.

Decomposition:
- Shared package holds:
  - DATA_W/ADDR_W defaults.
  - ZERO_REG constant (0).
  - Requester index constants REQ_A=0, REQ_B=1.
- One natural sub-module: rr_arb2. It is a 2-way round-robin arbiter (valids, prio in; grant one-hot out; combinational, with the pointer held in the parent).
- The output stage and hazard compare stay in the top.

Test Plan:
- Reset: hold rst_n=0 with a_valid=b_valid=1 -> a_ready=b_ready=0, rf_wren=0, rf_wr=0, rf_wd=0. Release -> first grant goes to A.
- Single requester: a_valid=1, a_addr=5, a_data=0xDEADBEEF for 1 cycle -> a_ready=1 that cycle; next cycle rf_wren=1, rf_wr=5, rf_wd=0xDEADBEEF; following cycle rf_wren=0.
- Contention: A (addr 3, 0x11) and B (addr 7, 0x22) valid and held for 4 cycles -> grants A,B,A,B; rf_wr sequence 3,7,3,7; last_grant 0,1,0,1.
- x0 drop: b_valid=1, b_addr=0, b_data=0xFFFFFFFF -> b_ready=1, next cycle rf_wren=0, and the pointer still advances to A.
- Hazard: A writes addr 9 while chk_addr=9 -> chk_hit=1 exactly in the rf_wren cycle. chk_addr=10 in the same cycle -> chk_hit=0.
- Async reset mid-stream: assert rst_n=0 between clock edges while rf_wren=1 -> rf_wren drops immediately, without waiting for a clock edge. After release, no stale write is issued.
